ospfb_fft_cfg_ctrl: RTL and testbench

- Initiator/consumer for the side channels of the OSPFB FFT core: drives the AXI-Stream config channel (direction bit, scale schedule) and consumes the per-frame status channel (overflow flag).
- Sits beside the FFT, downstream of the phase-compensation buffer.
- Issues the initial config after reset and re-issues on request.
- Keeps saturating frame/overflow statistics for software and test benches.

---
 rtl/ospfb_fft_cfg_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ospfb_fft_cfg_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ospfb_fft_cfg_ctrl.sv
// ospfb_fft_cfg_ctrl: drives the OSPFB FFT config channel and consumes its
// per-frame status channel, keeping saturating frame/overflow statistics.
// Optional build macro: OSPFB_FFT_AUTOSCALE_EN (overflow beats bump the scale
// schedule and queue a new config; adds the sched_sat output).
module ospfb_fft_cfg_ctrl #(
  parameter int unsigned FFT_LEN      = 2048,
  parameter int unsigned FFT_CONF_WID = 16,
  parameter int unsigned FFT_STAT_WID = 8,
  localparam int unsigned SCH_WID     = 2 * (($clog2(FFT_LEN) + 1) / 2),
  parameter logic [SCH_WID-1:0] DEF_SCALE_SCH = 12'hAAA,
  parameter logic DEF_FWD_INV         = 1'b1,
  parameter int unsigned CNT_WID      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_update,
  input  logic                    cfg_fwd_inv,
  input  logic [SCH_WID-1:0]      cfg_scale_sch,
  output logic [FFT_CONF_WID-1:0] m_axis_config_tdata,
  output logic                    m_axis_config_tvalid,
  input  logic                    m_axis_config_tready,
  input  logic [FFT_STAT_WID-1:0] s_axis_status_tdata,
  input  logic                    s_axis_status_tvalid,
  output logic                    s_axis_status_tready,
  input  logic                    clr_stats,
`ifdef OSPFB_FFT_AUTOSCALE_EN
  output logic                    sched_sat,
`endif
  output logic                    cfg_busy,
  output logic                    cfg_done,
  output logic [SCH_WID-1:0]      cur_scale_sch,
  output logic [CNT_WID-1:0]      frame_cnt,
  output logic [CNT_WID-1:0]      ovflo_cnt,
  output logic                    ovflo_sticky
);

  // Shadow/pending words hold {scale_sch, fwd_inv}
  localparam int unsigned CFG_WID = SCH_WID + 1;
  localparam int unsigned NSTG    = SCH_WID / 2;

  typedef enum logic [1:0] {ST_INIT, ST_SEND, ST_IDLE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CFG_WID-1:0]  r_shadow, w_shadow_nxt;
  logic [CFG_WID-1:0]  r_pend_word, w_pend_word_nxt;
  logic                r_pend, w_pend_nxt;
  logic                r_tvalid, r_stat_tready, r_busy, r_done, r_sticky;
  logic [FFT_CONF_WID-1:0] r_tdata;
  logic [SCH_WID-1:0]  r_cur_sch;
  logic [CNT_WID-1:0]  r_frame_cnt, r_ovflo_cnt, w_frame_base, w_ovflo_base;
  logic                w_hs, w_beat, w_ovf, w_req;
  logic [CFG_WID-1:0]  w_req_word;
  logic                w_unused_stat;

  assign w_hs   = r_tvalid & m_axis_config_tready;
  assign w_beat = s_axis_status_tvalid & r_stat_tready;
  assign w_ovf  = w_beat & s_axis_status_tdata[0];
  assign w_unused_stat = ^{s_axis_status_tdata[FFT_STAT_WID-1:1]};

`ifdef OSPFB_FFT_AUTOSCALE_EN
  logic               w_found, w_auto_sat, r_sched_sat;
  logic [CFG_WID-1:0] w_auto_word;

  // Bump the lowest stage field that is not yet at 3 (fwd_inv kept)
  always_comb begin
    w_auto_word = r_shadow;
    w_found     = 1'b0;
    for (int i = 0; i < NSTG; i++) begin
      if (!w_found && r_shadow[2*i+1 +: 2] != 2'b11) begin
        w_auto_word[2*i+1 +: 2] = r_shadow[2*i+1 +: 2] + 2'd1;
        w_found = 1'b1;
      end
    end
    w_auto_sat = w_ovf & ~w_found;
    w_req      = cfg_update | (w_ovf & w_found);
    w_req_word = cfg_update ? {cfg_scale_sch, cfg_fwd_inv} : w_auto_word;
  end

  assign sched_sat = r_sched_sat;
`else
  assign w_req      = cfg_update;
  assign w_req_word = {cfg_scale_sch, cfg_fwd_inv};
`endif

  // Next-state, shadow and pending-request logic
  always_comb begin
    w_state_nxt     = r_state;
    w_shadow_nxt    = r_shadow;
    w_pend_nxt      = r_pend;
    w_pend_word_nxt = r_pend_word;
    case (r_state)
      ST_INIT: begin
        w_shadow_nxt = {DEF_SCALE_SCH, DEF_FWD_INV};
        w_state_nxt  = ST_SEND;
        if (w_req) begin
          w_pend_nxt      = 1'b1;
          w_pend_word_nxt = w_req_word;
        end
      end
      ST_SEND: begin
        if (w_req) begin
          w_pend_nxt      = 1'b1;
          w_pend_word_nxt = w_req_word;
        end
        if (w_hs) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_req) begin
          w_shadow_nxt = w_req_word;
          w_pend_nxt   = 1'b0;
          w_state_nxt  = ST_SEND;
        end else if (r_pend) begin
          w_shadow_nxt = r_pend_word;
          w_pend_nxt   = 1'b0;
          w_state_nxt  = ST_SEND;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // State register and registered config-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_INIT;
      r_shadow      <= {DEF_SCALE_SCH, DEF_FWD_INV};
      r_pend        <= 1'b0;
      r_pend_word   <= '0;
      r_tvalid      <= 1'b0;
      r_tdata       <= '0;
      r_stat_tready <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cur_sch     <= DEF_SCALE_SCH;
    end else begin
      r_state       <= w_state_nxt;
      r_shadow      <= w_shadow_nxt;
      r_pend        <= w_pend_nxt;
      r_pend_word   <= w_pend_word_nxt;
      r_tvalid      <= (w_state_nxt == ST_SEND);
      r_tdata       <= FFT_CONF_WID'(w_shadow_nxt);
      r_stat_tready <= 1'b1;
      r_busy        <= (w_state_nxt != ST_IDLE) | w_pend_nxt;
      r_done        <= w_hs;
      if (w_hs) r_cur_sch <= r_shadow[CFG_WID-1:1];
    end
  end

  // Clear first, then apply this cycle's beat; counters stick at all-ones
  assign w_frame_base = clr_stats ? '0 : r_frame_cnt;
  assign w_ovflo_base = clr_stats ? '0 : r_ovflo_cnt;

  // Saturating status statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_ovflo_cnt <= '0;
      r_sticky    <= 1'b0;
`ifdef OSPFB_FFT_AUTOSCALE_EN
      r_sched_sat <= 1'b0;
`endif
    end else begin
      r_frame_cnt <= (w_beat && w_frame_base != '1) ? w_frame_base + CNT_WID'(1) : w_frame_base;
      r_ovflo_cnt <= (w_ovf && w_ovflo_base != '1) ? w_ovflo_base + CNT_WID'(1) : w_ovflo_base;
      r_sticky    <= (r_sticky & ~clr_stats) | w_ovf;
`ifdef OSPFB_FFT_AUTOSCALE_EN
      r_sched_sat <= (r_sched_sat & ~clr_stats) | w_auto_sat;
`endif
    end
  end

  assign m_axis_config_tdata  = r_tdata;
  assign m_axis_config_tvalid = r_tvalid;
  assign s_axis_status_tready = r_stat_tready;
  assign cfg_busy             = r_busy;
  assign cfg_done             = r_done;
  assign cur_scale_sch        = r_cur_sch;
  assign frame_cnt            = r_frame_cnt;
  assign ovflo_cnt            = r_ovflo_cnt;
  assign ovflo_sticky         = r_sticky;

endmodule

// File: tb/tb_ospfb_fft_cfg_ctrl.sv
// Self-checking bench for ospfb_fft_cfg_ctrl (default build and, when
// OSPFB_FFT_AUTOSCALE_EN is defined, the auto-rescale feature).
module tb_ospfb_fft_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_update = 1'b0;
  logic        cfg_fwd_inv = 1'b0;
  logic [11:0] cfg_scale_sch = '0;
  logic [15:0] m_tdata, c4_tdata;
  logic        m_tvalid, c4_tvalid;
  logic        m_tready = 1'b0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready, s4_tready;
  logic        clr_stats = 1'b0;
  logic        cfg_busy, cfg_done, b4_busy, d4_done;
  logic [11:0] cur_sch, c4_sch;
  logic [31:0] frame_cnt, ovflo_cnt;
  logic [3:0]  f4_cnt, o4_cnt;
  logic        sticky, sticky4;
`ifdef OSPFB_FFT_AUTOSCALE_EN
  logic        sched_sat, sched_sat4;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [15:0] obs_q[$];
  int          obs_cyc[$];

  always #5 clk = ~clk;

  ospfb_fft_cfg_ctrl u_dut (
    .clk(clk), .rst(rst),
    .cfg_update(cfg_update), .cfg_fwd_inv(cfg_fwd_inv), .cfg_scale_sch(cfg_scale_sch),
    .m_axis_config_tdata(m_tdata), .m_axis_config_tvalid(m_tvalid),
    .m_axis_config_tready(m_tready),
    .s_axis_status_tdata(s_tdata), .s_axis_status_tvalid(s_tvalid),
    .s_axis_status_tready(s_tready), .clr_stats(clr_stats),
`ifdef OSPFB_FFT_AUTOSCALE_EN
    .sched_sat(sched_sat),
`endif
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cur_scale_sch(cur_sch),
    .frame_cnt(frame_cnt), .ovflo_cnt(ovflo_cnt), .ovflo_sticky(sticky)
  );

  // Narrow-counter instance used to reach saturation quickly
  ospfb_fft_cfg_ctrl #(.CNT_WID(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .cfg_update(cfg_update), .cfg_fwd_inv(cfg_fwd_inv), .cfg_scale_sch(cfg_scale_sch),
    .m_axis_config_tdata(c4_tdata), .m_axis_config_tvalid(c4_tvalid),
    .m_axis_config_tready(m_tready),
    .s_axis_status_tdata(s_tdata), .s_axis_status_tvalid(s_tvalid),
    .s_axis_status_tready(s4_tready), .clr_stats(clr_stats),
`ifdef OSPFB_FFT_AUTOSCALE_EN
    .sched_sat(sched_sat4),
`endif
    .cfg_busy(b4_busy), .cfg_done(d4_done), .cur_scale_sch(c4_sch),
    .frame_cnt(f4_cnt), .ovflo_cnt(o4_cnt), .ovflo_sticky(sticky4)
  );

  // Record every accepted config word and the cycle it was accepted in
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && m_tvalid && m_tready) begin
      obs_q.push_back(m_tdata);
      obs_cyc.push_back(cyc);
    end
  end

  function automatic logic [15:0] cw(input logic f, input logic [11:0] s);
    return {3'b000, s, f};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cfg(input logic f, input logic [11:0] s);
    cfg_update = 1'b1; cfg_fwd_inv = f; cfg_scale_sch = s;
    step();
    cfg_update = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd_ready, input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      if (!cfg_busy && !m_tvalid) break;
      if (rnd_ready) m_tready = 1'($urandom_range(0, 1));
      step();
    end
    n_tests++;
    if (k == 300) begin
      n_fail++;
      $display("FAIL %s idle_timeout: busy=%0b tvalid=%0b, required idle", name, cfg_busy, m_tvalid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; m_tready = 1'b0; s_tvalid = 1'b0; clr_stats = 1'b0;
    repeat (3) step();
    n_tests++;
    if ({m_tvalid, m_tdata, s_tready, cfg_busy, cfg_done, cur_sch, frame_cnt, ovflo_cnt, sticky} !==
        {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 12'hAAA, 32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: tv=%0b td=%h str=%0b busy=%0b done=%0b sch=%h fc=%0d oc=%0d st=%0b",
               m_tvalid, m_tdata, s_tready, cfg_busy, cfg_done, cur_sch, frame_cnt, ovflo_cnt, sticky);
    end
    m_tready = 1'b1;
    rst = 1'b0;
    obs_q.delete(); obs_cyc.delete();
    n_tests++;
    if (m_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL init_cycle1: tvalid=%0b required 0", m_tvalid);
    end
    step();
    n_tests++;
    if (m_tvalid !== 1'b1 || m_tdata !== 16'h1555) begin
      n_fail++; $display("FAIL init_cycle2: tvalid=%0b tdata=%h required 1/1555", m_tvalid, m_tdata);
    end
    step();
    n_tests++;
    if (cfg_done !== 1'b1 || cur_sch !== 12'hAAA || m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL init_done: done=%0b sch=%h tvalid=%0b required 1/AAA/0", cfg_done, cur_sch, m_tvalid);
    end
    step();
    n_tests++;
    if (cfg_done !== 1'b0 || cfg_busy !== 1'b0 || obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL init_settle: done=%0b busy=%0b words=%0d required 0/0/1", cfg_done, cfg_busy, obs_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic        f;
    logic [11:0] s;
    logic [15:0] exp;
    bit          stable;
    wait_idle(1'b0, "bp");
    m_tready = 1'b0;
    f = 1'($urandom); s = 12'($urandom);
    exp = cw(f, s);
    obs_q.delete(); obs_cyc.delete();
    pulse_cfg(f, s);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (m_tvalid !== 1'b1 || m_tdata !== exp) stable = 1'b0;
      step();
    end
    n_tests++;
    if (!stable) begin
      n_fail++; $display("FAIL bp_stable: tdata=%h tvalid=%0b required %h held", m_tdata, m_tvalid, exp);
    end
    m_tready = 1'b1;
    wait_idle(1'b0, "bp");
    n_tests++;
    if (obs_q.size() != 1 || obs_q[0] !== exp || cur_sch !== s) begin
      n_fail++;
      $display("FAIL bp_single: words=%0d sch=%h required 1 word %h sch %h", obs_q.size(), cur_sch, exp, s);
    end
  endtask

  task automatic test_pending();
    wait_idle(1'b0, "pend");
    m_tready = 1'b0;
    obs_q.delete(); obs_cyc.delete();
    pulse_cfg(1'b1, 12'hAAA);
    pulse_cfg(1'b0, 12'h555);
    pulse_cfg(1'b1, 12'hFFF);
    step(); step();
    m_tready = 1'b1;
    wait_idle(1'b0, "pend");
    n_tests++;
    if (obs_q.size() != 2) begin
      n_fail++; $display("FAIL pend_count: words=%0d required 2", obs_q.size());
    end else begin
      n_tests++;
      if (obs_q[0] !== 16'h1555 || obs_q[1] !== 16'h1FFF || obs_cyc[1] - obs_cyc[0] != 2) begin
        n_fail++;
        $display("FAIL pend_words: %h,%h gap=%0d required 1555,1FFF gap 2",
                 obs_q[0], obs_q[1], obs_cyc[1] - obs_cyc[0]);
      end
    end
    n_tests++;
    if (cur_sch !== 12'hFFF) begin
      n_fail++; $display("FAIL pend_cur_sch: %h required FFF", cur_sch);
    end
  endtask

  task automatic test_random_cfg();
    logic [15:0] exp_q[$];
    logic        f;
    logic [11:0] s, last_s;
    int          n_extra;
    for (int it = 0; it < 25; it++) begin
      wait_idle(1'b1, "rnd_cfg");
      m_tready = 1'b0;
      obs_q.delete(); obs_cyc.delete(); exp_q.delete();
      f = 1'($urandom); s = 12'($urandom);
      pulse_cfg(f, s);
      exp_q.push_back(cw(f, s));
      last_s = s;
      n_extra = int'($urandom_range(0, 3));
      for (int e = 0; e < n_extra; e++) begin
        f = 1'($urandom); s = 12'($urandom);
        pulse_cfg(f, s);
        repeat ($urandom_range(0, 2)) step();
      end
      if (n_extra > 0) begin
        exp_q.push_back(cw(f, s));
        last_s = s;
      end
      wait_idle(1'b1, "rnd_cfg");
      n_tests++;
      if (obs_q != exp_q || cur_sch !== last_s) begin
        n_fail++;
        $display("FAIL rnd_cfg it=%0d: words=%0d first=%h sch=%h required words=%0d first=%h sch=%h",
                 it, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 16'h0, cur_sch,
                 exp_q.size(), exp_q[0], last_s);
      end
    end
    m_tready = 1'b1;
  endtask

  task automatic test_reset_mid();
    wait_idle(1'b0, "rst_mid");
    m_tready = 1'b0;
    pulse_cfg(1'($urandom), 12'($urandom));
    pulse_cfg(1'($urandom), 12'($urandom));
    m_tready = 1'b1;
    rst = 1'b1;
    step();
    n_tests++;
    if (m_tvalid !== 1'b0 || cfg_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_drop: tvalid=%0b busy=%0b required 0/0", m_tvalid, cfg_busy);
    end
    rst = 1'b0;
    obs_q.delete(); obs_cyc.delete();
    step();
    wait_idle(1'b0, "rst_mid");
    repeat (3) step();
    n_tests++;
    if (obs_q.size() != 1 || obs_q[0] !== 16'h1555 || cur_sch !== 12'hAAA) begin
      n_fail++;
      $display("FAIL rst_mid_resend: words=%0d sch=%h required 1 word 1555 sch AAA", obs_q.size(), cur_sch);
    end
  endtask

`ifdef OSPFB_FFT_AUTOSCALE_EN
  task automatic test_autoscale();
    obs_q.delete(); obs_cyc.delete();
    s_tvalid = 1'b1; s_tdata = 8'h01;
    step();
    s_tvalid = 1'b0;
    wait_idle(1'b0, "auto");
    n_tests++;
    if (obs_q.size() != 1 || obs_q[0] !== cw(1'b1, 12'hAAB)) begin
      n_fail++; $display("FAIL auto_bump: words=%0d required 1 word %h", obs_q.size(), cw(1'b1, 12'hAAB));
    end
    pulse_cfg(1'b1, 12'hFFF);
    wait_idle(1'b0, "auto");
    obs_q.delete(); obs_cyc.delete();
    s_tvalid = 1'b1; s_tdata = 8'h01;
    step();
    s_tvalid = 1'b0;
    repeat (5) step();
    n_tests++;
    if (obs_q.size() != 0 || sched_sat !== 1'b1) begin
      n_fail++; $display("FAIL auto_sat: words=%0d sat=%0b required 0/1", obs_q.size(), sched_sat);
    end
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    n_tests++;
    if (sched_sat !== 1'b0) begin
      n_fail++; $display("FAIL auto_sat_clr: sat=%0b required 0", sched_sat);
    end
  endtask
`endif

  task automatic test_status();
    logic [7:0] pat [5];
    pat[0] = 8'h00; pat[1] = 8'h01; pat[2] = 8'h01; pat[3] = 8'h00; pat[4] = 8'h01;
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1; s_tdata = pat[i];
      step();
    end
    s_tvalid = 1'b0;
    n_tests++;
    if (frame_cnt !== 32'd5 || ovflo_cnt !== 32'd3 || sticky !== 1'b1) begin
      n_fail++; $display("FAIL stat_5beats: fc=%0d oc=%0d st=%0b required 5/3/1", frame_cnt, ovflo_cnt, sticky);
    end
    clr_stats = 1'b1; s_tvalid = 1'b1; s_tdata = 8'h00;
    step();
    clr_stats = 1'b0; s_tvalid = 1'b0;
    n_tests++;
    if (frame_cnt !== 32'd1 || ovflo_cnt !== 32'd0 || sticky !== 1'b0) begin
      n_fail++; $display("FAIL stat_clr_beat: fc=%0d oc=%0d st=%0b required 1/0/0", frame_cnt, ovflo_cnt, sticky);
    end
  endtask

  task automatic test_random_stats();
    longint f = 1, o = 0, f4 = 1, o4 = 0;
    bit     st = 1'b0;
    bit     beat, ov;
    for (int i = 0; i < 400; i++) begin
      s_tvalid  = ($urandom_range(0, 3) != 0);
      s_tdata   = 8'($urandom);
      clr_stats = ($urandom_range(0, 24) == 0);
      beat = s_tvalid;
      ov   = s_tvalid && s_tdata[0];
      if (clr_stats) begin f = 0; o = 0; f4 = 0; o4 = 0; st = 1'b0; end
      if (beat) begin
        f  = (f  < 64'hFFFF_FFFF) ? f + 1 : f;
        f4 = (f4 < 15) ? f4 + 1 : f4;
      end
      if (ov) begin
        o  = (o  < 64'hFFFF_FFFF) ? o + 1 : o;
        o4 = (o4 < 15) ? o4 + 1 : o4;
        st = 1'b1;
      end
      step();
      n_tests++;
      if (frame_cnt !== 32'(f) || ovflo_cnt !== 32'(o) || sticky !== st ||
          f4_cnt !== 4'(f4) || o4_cnt !== 4'(o4) || sticky4 !== st) begin
        n_fail++;
        $display("FAIL rnd_stats i=%0d: fc=%0d oc=%0d st=%0b f4=%0d o4=%0d required %0d/%0d/%0b %0d/%0d",
                 i, frame_cnt, ovflo_cnt, sticky, f4_cnt, o4_cnt, f, o, st, f4, o4);
      end
    end
    s_tvalid = 1'b0; clr_stats = 1'b0;
  endtask

  task automatic test_saturation();
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    s_tvalid = 1'b1; s_tdata = 8'h01;
    repeat (20) step();
    s_tvalid = 1'b0;
    n_tests++;
    if (f4_cnt !== 4'hF || o4_cnt !== 4'hF || frame_cnt !== 32'd20 || ovflo_cnt !== 32'd20) begin
      n_fail++;
      $display("FAIL sat_hold: f4=%h o4=%h fc=%0d oc=%0d required F/F/20/20", f4_cnt, o4_cnt, frame_cnt, ovflo_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_backpressure();
    test_pending();
    test_random_cfg();
    test_reset_mid();
`ifdef OSPFB_FFT_AUTOSCALE_EN
    test_autoscale();
`endif
    test_status();
    test_random_stats();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
